// File: rtl/mover_pkg.sv
// Shared types for the mover slot scheduler: slot record, FSM states, fixed-point format.
package mover_pkg;

  localparam int FRAC_BITS = 6;
  localparam int POS_W     = 11 + FRAC_BITS;

  typedef struct packed {
    logic              active;
    logic signed [16:0] pos;
    logic signed [11:0] speed;
    logic signed [10:0] y;
  } mover_slot_t;

  typedef enum logic {S_IDLE, S_UPDATE} mover_state_e;

endpackage

// File: rtl/mover_slot_scheduler_free_slot_finder.sv
// Lowest-index free slot encoder: returns the first cleared bit of active and a full flag.
module free_slot_finder #(
  parameter int NUM_SLOTS = 4,
  localparam int IW = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] active,
  output logic [IW-1:0]        idx,
  output logic                 full
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !active[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign full = &active;

endmodule

// File: rtl/mover_slot_scheduler.sv
// Shares one fixed-point X adder across all mover slots, sweeping one slot per cycle each frame,
// and allocates/frees slots on spawn, kill and off-screen events.
module mover_slot_scheduler
  import mover_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int X_MIN     = -32,
  parameter int X_MAX     = 640,
  localparam int IW = $clog2(NUM_SLOTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic                        spawn_req,
  input  logic signed [10:0]          spawn_x,
  input  logic signed [10:0]          spawn_y,
  input  logic signed [11:0]          spawn_speed,
  input  logic [NUM_SLOTS-1:0]        kill_req,
  output logic                        spawn_ack,
  output logic [IW-1:0]               spawn_slot,
  output logic                        slots_full,
  output logic [NUM_SLOTS-1:0]        active,
  output logic [NUM_SLOTS-1:0][10:0]  topLeftX,
  output logic [NUM_SLOTS-1:0][10:0]  topLeftY,
  output logic [NUM_SLOTS-1:0]        despawn,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam logic signed [11:0] X_LO = 12'(X_MIN);
  localparam logic signed [11:0] X_HI = 12'(X_MAX);

  mover_slot_t  slots   [NUM_SLOTS];
  mover_slot_t  slots_n [NUM_SLOTS];
  mover_slot_t  cur;
  mover_state_e state, state_n;
  logic [IW-1:0] idx, idx_n, free_idx, slot_n;
  logic          full, ack_n, ovr_n, out_of_range;
  logic [NUM_SLOTS-1:0] desp_n;
  logic signed [POS_W:0]  sum;
  logic signed [11:0]     new_x;

  free_slot_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
    .active (active),
    .idx    (free_idx),
    .full   (full)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      active[i]   = slots[i].active;
      topLeftX[i] = slots[i].pos[POS_W-1:FRAC_BITS];
      topLeftY[i] = slots[i].y;
    end
  end

  assign slots_full = full;
  assign frame_done = (state == S_UPDATE) && (idx == IW'(NUM_SLOTS - 1));

  // One guard bit on the adder so the bounds check sees the true sum.
  assign cur          = slots[idx];
  assign sum          = (POS_W + 1)'(cur.pos) + (POS_W + 1)'(cur.speed);
  assign new_x        = sum[POS_W:FRAC_BITS];
  assign out_of_range = (new_x < X_LO) || (new_x > X_HI);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    slots_n = slots;
    ack_n   = 1'b0;
    slot_n  = spawn_slot;
    desp_n  = '0;
    ovr_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (startOfFrame) begin
          state_n = S_UPDATE;
          idx_n   = '0;
        end else if (spawn_req && !full && !spawn_ack && !kill_req[free_idx]) begin
          slots_n[free_idx].active = 1'b1;
          slots_n[free_idx].pos    = {spawn_x, {FRAC_BITS{1'b0}}};
          slots_n[free_idx].speed  = spawn_speed;
          slots_n[free_idx].y      = spawn_y;
          ack_n  = 1'b1;
          slot_n = free_idx;
        end
      end
      S_UPDATE: begin
        ovr_n = startOfFrame;
        if (cur.active && !kill_req[idx]) begin
          slots_n[idx].pos = sum[POS_W-1:0];
          if (out_of_range) begin
            slots_n[idx].active = 1'b0;
            desp_n[idx]         = 1'b1;
          end
        end
        if (idx == IW'(NUM_SLOTS - 1)) state_n = S_IDLE;
        else                           idx_n   = idx + IW'(1);
      end
    endcase
    // Kills are applied last so they win over a same-cycle update or spawn.
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (kill_req[i]) slots_n[i].active = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      spawn_ack  <= 1'b0;
      spawn_slot <= '0;
      despawn    <= '0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      spawn_ack  <= ack_n;
      spawn_slot <= slot_n;
      despawn    <= desp_n;
      overrun    <= ovr_n;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= slots_n[i];
    end
  end

endmodule
